// File: rtl/sum_operand_sequencer.sv
// Collects N serial operands, launches the K-cycle summer with a one-cycle start pulse,
// then returns the summer result and a flag that is set when it disagrees with a locally accumulated sum.
module sum_operand_sequencer #(
    parameter int N  = 10,
    parameter int W  = 5,
    parameter int K  = 4,
    parameter int RW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic [N*W-1:0]  op_flat,
    output logic            op_start,
    input  logic [RW-1:0]   sum_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [RW-1:0]   res_data,
    output logic            res_mismatch
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [RW-1:0]          acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N-1:0][W-1:0]    buf_q, buf_d;
    logic [RW-1:0]          res_data_q, res_data_d;
    logic                   res_mm_q, res_mm_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            idx_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            res_data_q <= '0;
            res_mm_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            res_data_q <= res_data_d;
            res_mm_q   <= res_mm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        res_data_d = res_data_q;
        res_mm_d   = res_mm_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    buf_d[idx_q] = in_data;
                    acc_d        = acc_q + RW'(in_data);
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = LAUNCH;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            LAUNCH: begin
                cnt_d   = CW'(K);
                state_d = WAIT;
            end
            WAIT: begin
                // Count of 1 marks the cycle in which the summer output is valid.
                if (cnt_q == CW'(1)) begin
                    res_data_d = sum_in;
                    res_mm_d   = (sum_in != acc_q);
                    cnt_d      = '0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    acc_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign op_flat      = buf_q;
    assign in_ready     = (state_q == FILL);
    assign op_start     = (state_q == LAUNCH);
    assign res_valid    = (state_q == DONE);
    assign res_data     = res_data_q;
    assign res_mismatch = res_mm_q;

endmodule

// File: tb/tb_sum_operand_sequencer.sv
// Directed bench for sum_operand_sequencer with a fixed-latency summer model.
module tb_sum_operand_sequencer;

    localparam int N  = 10;
    localparam int W  = 5;
    localparam int K  = 4;
    localparam int RW = 10;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [N*W-1:0]  op_flat;
    logic            op_start;
    logic [RW-1:0]   sum_in;
    logic            res_valid;
    logic            res_ready;
    logic [RW-1:0]   res_data;
    logic            res_mismatch;

    int tests;
    int fails;
    int err;
    int scnt;
    int ncyc;
    logic [W-1:0]  ops [N];
    logic [RW-1:0] model_sum;

    sum_operand_sequencer #(.N(N), .W(W), .K(K), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .op_flat(op_flat), .op_start(op_start), .sum_in(sum_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_mismatch(res_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Summer model: result is only meaningful in the K-th cycle after op_start.
    always_comb begin
        model_sum = '0;
        for (int i = 0; i < N; i++) model_sum = model_sum + RW'(op_flat[i*W +: W]);
    end
    assign sum_in = (scnt == K) ? model_sum + RW'(err) : RW'(1000);

    always @(posedge clk) begin
        if (rst)              scnt <= 0;
        else if (op_start)    scnt <= 1;
        else if (scnt == K)   scnt <= 0;
        else if (scnt != 0)   scnt <= scnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_ops();
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = ops[i];
        return r;
    endfunction

    task automatic check_reset_state();
        check("rst_in_ready", in_ready, 1);
        check("rst_op_start", op_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_mismatch", res_mismatch, 0);
        check("rst_op_flat", op_flat, 0);
    endtask

    task automatic feed(input bit bubbles, output int n);
        n = 0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i];
            check("fill_in_ready", in_ready, 1);
            check("fill_op_start", op_start, 0);
            tick();
            n++;
            if (bubbles && i < N - 1) begin
                in_valid = 1'b0;
                in_data  = 5'h1f;
                tick();
                n++;
            end
        end
        in_valid = 1'b0;
    endtask

    // Called in the LAUNCH cycle; junk words are offered throughout to prove they are ignored.
    task automatic finish_frame(input logic [RW-1:0] exp_data, input bit exp_mm, input int hold);
        logic [N*W-1:0] exp_flat;
        exp_flat = pack_ops();
        in_valid = 1'b1;
        in_data  = 5'h1f;
        check("launch_op_start", op_start, 1);
        check("launch_in_ready", in_ready, 0);
        check("launch_res_valid", res_valid, 0);
        check("launch_op_flat", op_flat, exp_flat);
        for (int k = 1; k <= K; k++) begin
            tick();
            check("wait_op_start", op_start, 0);
            check("wait_in_ready", in_ready, 0);
            check("wait_res_valid", res_valid, 0);
            check("wait_op_flat", op_flat, exp_flat);
        end
        tick();
        for (int h = 0; h <= hold; h++) begin
            check("done_res_valid", res_valid, 1);
            check("done_res_data", res_data, exp_data);
            check("done_res_mismatch", res_mismatch, exp_mm);
            check("done_in_ready", in_ready, 0);
            if (h == hold) res_ready = 1'b1;
            tick();
        end
        res_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_res_valid", res_valid, 0);
    endtask

    initial begin
        tests = 0; fails = 0; err = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state();

        // Operands 1..10, streaming
        for (int i = 0; i < N; i++) ops[i] = W'(i + 1);
        feed(1'b0, ncyc);
        check("t1_launch_cycle", ncyc, 10);
        finish_frame(10'd55, 1'b0, 0);

        // All-max operands
        for (int i = 0; i < N; i++) ops[i] = 5'd31;
        feed(1'b0, ncyc);
        check("t2_flat_ones", op_flat, {(N*W){1'b1}});
        finish_frame(10'd310, 1'b0, 0);

        // Bubbled input, operands 0..9
        for (int i = 0; i < N; i++) ops[i] = W'(i);
        feed(1'b1, ncyc);
        check("t3_fill_cycles", ncyc, 19);
        finish_frame(10'd45, 1'b0, 0);

        // Faulty summer, downstream stall of 5 cycles
        for (int i = 0; i < N; i++) ops[i] = W'(i + 1);
        err = 1;
        feed(1'b0, ncyc);
        finish_frame(10'd56, 1'b1, 5);
        err = 0;

        // Back-to-back frames
        feed(1'b0, ncyc);
        finish_frame(10'd55, 1'b0, 0);
        for (int i = 0; i < N; i++) ops[i] = 5'd2;
        feed(1'b0, ncyc);
        finish_frame(10'd20, 1'b0, 0);

        // Reset after 6 operands
        for (int i = 0; i < N; i++) ops[i] = W'(i + 1);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i];
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();
        for (int i = 0; i < 12; i++) begin
            check("rst1_no_start", op_start, 0);
            tick();
        end

        // Reset during WAIT
        feed(1'b0, ncyc);
        check("rst2_launch", op_start, 1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();
        for (int i = 0; i < 10; i++) begin
            check("rst2_no_start", op_start, 0);
            check("rst2_no_valid", res_valid, 0);
            tick();
        end

        // Clean frame of 3s after the resets
        for (int i = 0; i < N; i++) ops[i] = 5'd3;
        feed(1'b0, ncyc);
        check("t6_launch_cycle", ncyc, 10);
        finish_frame(10'd30, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
